// File: rtl/bldc_pkg.sv
// Shared sector constants, phase request type and commutation lookups for the
// six-step BLDC commutator.
package bldc_pkg;

    localparam logic [2:0] SECTOR_0       = 3'd0;
    localparam logic [2:0] SECTOR_1       = 3'd1;
    localparam logic [2:0] SECTOR_2       = 3'd2;
    localparam logic [2:0] SECTOR_3       = 3'd3;
    localparam logic [2:0] SECTOR_4       = 3'd4;
    localparam logic [2:0] SECTOR_5       = 3'd5;
    localparam logic [2:0] SECTOR_INVALID = 3'd7;

    typedef enum logic [1:0] {
        REQ_Z = 2'd0,
        REQ_H = 2'd1,
        REQ_L = 2'd2
    } phase_req_e;

    typedef struct packed {
        phase_req_e a;
        phase_req_e b;
        phase_req_e c;
    } bridge_req_t;

    // Hall code is {h1,h2,h3}; 000 and 111 are physically impossible.
    function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
        logic [2:0] sector;
        case (hall)
            3'b100:  sector = SECTOR_0;
            3'b110:  sector = SECTOR_1;
            3'b010:  sector = SECTOR_2;
            3'b011:  sector = SECTOR_3;
            3'b001:  sector = SECTOR_4;
            3'b101:  sector = SECTOR_5;
            default: sector = SECTOR_INVALID;
        endcase
        return sector;
    endfunction

    function automatic phase_req_e swap_side(input phase_req_e req);
        phase_req_e swapped;
        case (req)
            REQ_H:   swapped = REQ_L;
            REQ_L:   swapped = REQ_H;
            default: swapped = REQ_Z;
        endcase
        return swapped;
    endfunction

    function automatic phase_req_e gate_pwm(input phase_req_e req, input logic pwm_on);
        phase_req_e gated;
        gated = (req == REQ_H && !pwm_on) ? REQ_Z : req;
        return gated;
    endfunction

    function automatic bridge_req_t commutate(input logic [2:0] sector, input logic dir);
        bridge_req_t req;
        req.a = REQ_Z;
        req.b = REQ_Z;
        req.c = REQ_Z;
        case (sector)
            SECTOR_0: begin req.a = REQ_H; req.b = REQ_L; end
            SECTOR_1: begin req.a = REQ_H; req.c = REQ_L; end
            SECTOR_2: begin req.b = REQ_H; req.c = REQ_L; end
            SECTOR_3: begin req.b = REQ_H; req.a = REQ_L; end
            SECTOR_4: begin req.c = REQ_H; req.a = REQ_L; end
            SECTOR_5: begin req.c = REQ_H; req.b = REQ_L; end
            default:  ;
        endcase
        if (dir) begin
            req.a = swap_side(req.a);
            req.b = swap_side(req.b);
            req.c = swap_side(req.c);
        end
        return req;
    endfunction

endpackage

// File: rtl/dead_time_phase.sv
// One half-bridge: turns a Z/H/L request into registered hi/lo gate drives,
// never driving both and holding both off for DEAD_CYCLES on a side change.
module dead_time_phase
    import bldc_pkg::*;
#(
    parameter int DEAD_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  phase_req_e req,
    output logic       hi,
    output logic       lo
);

    localparam int                  CNT_BITS  = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] DEAD_LOAD = CNT_BITS'(DEAD_CYCLES);

    typedef enum logic [1:0] {ST_OFF, ST_HI, ST_LO, ST_DEAD} state_e;

    state_e              state, state_next;
    logic [CNT_BITS-1:0] dead_cnt, dead_cnt_next;
    logic                last_hi, last_hi_next;
    logic                expiring, may_hi, may_lo;

    // The edge on which the counter runs out already counts as elapsed, so an
    // H<->L swap keeps both gates off for exactly DEAD_CYCLES clocks.
    assign expiring = (dead_cnt <= CNT_BITS'(1));
    assign may_hi   = expiring || last_hi;
    assign may_lo   = expiring || !last_hi;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next    = state;
        last_hi_next  = last_hi;
        dead_cnt_next = (dead_cnt != '0) ? dead_cnt - CNT_BITS'(1) : dead_cnt;
        case (state)
            ST_HI: begin
                if (req != REQ_H) begin
                    state_next    = ST_DEAD;
                    dead_cnt_next = DEAD_LOAD;
                    last_hi_next  = 1'b1;
                end
            end
            ST_LO: begin
                if (req != REQ_L) begin
                    state_next    = ST_DEAD;
                    dead_cnt_next = DEAD_LOAD;
                    last_hi_next  = 1'b0;
                end
            end
            default: begin
                if (req == REQ_H && may_hi) begin
                    state_next = ST_HI;
                end else if (req == REQ_L && may_lo) begin
                    state_next = ST_LO;
                end else if (expiring) begin
                    state_next = ST_OFF;
                end else begin
                    state_next = ST_DEAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_OFF;
            dead_cnt <= '0;
            last_hi  <= 1'b0;
            hi       <= 1'b0;
            lo       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
            last_hi  <= last_hi_next;
            hi       <= (state_next == ST_HI);
            lo       <= (state_next == ST_LO);
        end
    end

endmodule

// File: rtl/hall_commutator.sv
// Six-step BLDC commutation: hall sync/filter, sector decode, high-side PWM,
// per-phase dead time and sector-period measurement.
module hall_commutator
    import bldc_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int DEAD_CYCLES   = 12,
    parameter int FILTER_CYCLES = 4,
    parameter int PERIOD_BITS   = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hall1,
    input  logic                   hall2,
    input  logic                   hall3,
    input  logic                   enable,
    input  logic                   dir,
    input  logic [PWM_BITS-1:0]    duty,
    output logic                   inha,
    output logic                   inla,
    output logic                   inhb,
    output logic                   inlb,
    output logic                   inhc,
    output logic                   inlc,
    output logic [2:0]             sector,
    output logic                   fault,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   period_valid
);

    localparam int                   FILT_BITS = $clog2(FILTER_CYCLES + 1);
    localparam logic [FILT_BITS-1:0] FILT_DONE = FILT_BITS'(FILTER_CYCLES);

    logic [2:0]             hall_meta, hall_sync, cand;
    logic [FILT_BITS-1:0]   cand_cnt, cand_cnt_next;
    logic                   accept, fault_new, sector_change;
    logic [2:0]             sector_new;
    logic [PERIOD_BITS-1:0] per_cnt;
    logic [PWM_BITS-1:0]    pwm_cnt, duty_q;
    logic                   pwm_on;
    bridge_req_t            phase_req;

    // A zero count marks the candidate as unseen, so the first sample after reset never matches.
    always_comb begin
        if (cand_cnt != '0 && hall_sync == cand) begin
            cand_cnt_next = (cand_cnt == FILT_DONE) ? cand_cnt : cand_cnt + FILT_BITS'(1);
        end else begin
            cand_cnt_next = FILT_BITS'(1);
        end
    end

    assign accept        = (cand_cnt_next == FILT_DONE);
    assign sector_new    = hall_to_sector(hall_sync);
    assign fault_new     = (hall_sync == 3'b000) || (hall_sync == 3'b111);
    assign sector_change = accept && (sector_new != sector);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hall_meta <= 3'b000;
            hall_sync <= 3'b000;
            cand      <= 3'b000;
            cand_cnt  <= '0;
            sector    <= SECTOR_INVALID;
            fault     <= 1'b0;
        end else begin
            hall_meta <= {hall1, hall2, hall3};
            hall_sync <= hall_meta;
            cand      <= hall_sync;
            cand_cnt  <= cand_cnt_next;
            if (accept) begin
                sector <= sector_new;
                fault  <= fault_new;
            end
        end
    end

    // Only valid-to-valid changes are a real rotor period; invalid codes restart from zero silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sector_change) begin
                if (sector != SECTOR_INVALID && sector_new != SECTOR_INVALID) begin
                    period       <= per_cnt;
                    period_valid <= 1'b1;
                    per_cnt      <= PERIOD_BITS'(1);
                end else begin
                    per_cnt <= '0;
                end
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + PERIOD_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == '1) begin
                duty_q <= duty;
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty_q);

    always_comb begin
        phase_req   = commutate(sector, dir);
        phase_req.a = gate_pwm(phase_req.a, pwm_on);
        phase_req.b = gate_pwm(phase_req.b, pwm_on);
        phase_req.c = gate_pwm(phase_req.c, pwm_on);
        if (!enable || fault) begin
            phase_req = '{a: REQ_Z, b: REQ_Z, c: REQ_Z};
        end
    end

    dead_time_phase #(.DEAD_CYCLES(DEAD_CYCLES)) u_phase_a (
        .clk(clk), .reset_n(reset_n), .req(phase_req.a), .hi(inha), .lo(inla)
    );
    dead_time_phase #(.DEAD_CYCLES(DEAD_CYCLES)) u_phase_b (
        .clk(clk), .reset_n(reset_n), .req(phase_req.b), .hi(inhb), .lo(inlb)
    );
    dead_time_phase #(.DEAD_CYCLES(DEAD_CYCLES)) u_phase_c (
        .clk(clk), .reset_n(reset_n), .req(phase_req.c), .hi(inhc), .lo(inlc)
    );

endmodule

// File: doc/hall_commutator.md
# hall_commutator

Six-step BLDC commutation stage between the pulled-up hall sensor inputs (`hall1..3`) and the six gate-driver outputs (`INHA/INLA`, `INHB/INLB`, `INHC/INLC`) on the TinyFPGA BX motor board. It has four jobs:
- synchronise and glitch-filter the hall code;
- decode the rotor sector and drive the commutation table with high-side PWM;
- insert dead time per half-bridge;
- measure the sector period for speed feedback.

## Interface
Parameters:
- `PWM_BITS`, 8, width of the duty input and the PWM counter.
- `DEAD_CYCLES`, 12, minimum clocks with both switches of one phase off before the opposite switch turns on. Minimum 1.
- `FILTER_CYCLES`, 4, consecutive identical synchronised samples required to accept a new hall code. Minimum 1.
- `PERIOD_BITS`, 24, width of the sector-period counter.

Ports:
- `clk` in 1, 12 MHz system clock. One clock domain; all logic is on `clk`.
- `reset_n` in 1, asynchronous active-low reset.
- `hall1`, `hall2`, `hall3` in 1 each, raw hall levels, asynchronous.
- `enable` in 1, bridge enable. When low, all gates are off.
- `dir` in 1, 0 = forward, 1 = reverse.
- `duty` in `PWM_BITS`, high-side on-time in counts per PWM period.
- `inha`, `inla`, `inhb`, `inlb`, `inhc`, `inlc` out 1 each, gate drives, registered.
- `sector` out 3, accepted sector 0..5. The value 7 means invalid or unknown.
- `fault` out 1, filtered hall code is 000 or 111.
- `period` out `PERIOD_BITS`, clocks between the last two accepted sector changes.
- `period_valid` out 1, one-cycle strobe when `period` updates.

## Operation
- **Synchroniser:** 2-FF per hall line. The filter holds a candidate code and a counter. It accepts the candidate once the code has been equal for `FILTER_CYCLES` consecutive samples. Any mismatch reloads the candidate and restarts the count.
- **Decode of {h1,h2,h3}:** 100→0, 110→1, 010→2, 011→3, 001→4, 101→5. Codes 000 and 111 give `sector`=7 and `fault`=1.
- **Forward drive, high-side (PWM) / low-side (steady on):**
  - sector 0: A/B
  - sector 1: A/C
  - sector 2: B/C
  - sector 3: B/A
  - sector 4: C/A
  - sector 5: C/B
  - The remaining phase is Z (both switches off).
- **Reverse drive:** swap the high and low phase of each table entry.
- **PWM:**
  - `pwm_cnt` free-runs 0..2^`PWM_BITS`−1 and wraps.
  - `duty` is latched when `pwm_cnt` equals its maximum value.
  - The high-side request is active while `pwm_cnt` < latched duty. Duty 0 means never on; duty 255 means on 255 of every 256 cycles.
- **Per-phase dead-time FSM:**
  - States: OFF, HI, LO, DEAD.
  - Any switch turning off loads the dead counter with `DEAD_CYCLES` and records the last side that was on.
  - A switch may turn on only in one of two cases: (a) the counter is 0, or (b) it is the same side that last turned off. Case (b) means PWM re-enable of the same high side incurs no dead time.
  - An H↔L request change passes through DEAD with both gates 0 for exactly `DEAD_CYCLES` clocks.
- **Forced-off conditions:** `enable`=0 or `fault`=1 forces every phase request to Z. The dead counters then run normally.
- **Period measurement:**
  - A counter increments every clock and saturates at all-ones.
  - On each accepted change between valid sectors: `period` takes the counter value, `period_valid` is driven to 1 for one cycle, and the counter restarts at 1.
  - Transitions into or out of sector 7 reset the counter to 0 and do not strobe.
- **Reset mid-operation:** all gates drop asynchronously. After release, nothing turns on until a valid filtered code has been accepted, which needs at least 2 + `FILTER_CYCLES` clocks.

## Timing
- Reset values:
  - all six gate outputs 0
  - `sector` 7
  - `fault` 0
  - `period` 0
  - `period_valid` 0
  - `pwm_cnt` 0
  - latched duty 0
  - dead counters 0
- Hall change to `sector`/`fault` update: 2 (sync) + `FILTER_CYCLES` clocks after the first edge that samples the new level.
- `sector` to gate outputs: 1 clock, plus `DEAD_CYCLES` on any H↔L swap within a phase.
- `enable` falling edge: gates are 0 on the next clock edge.
- `period_valid` is asserted in the same cycle as the `sector` update.
- Simultaneous wrap and duty change: the new duty is used from `pwm_cnt`=0 onward.

## Structure
- Package `bldc_pkg` holds:
  - sector constants, including `SECTOR_INVALID`=7
  - the phase request enum (Z, H, L)
  - the `hall_to_sector` function
  - the `commutate(sector, dir)` function returning the three phase requests
- Sub-module `dead_time_phase`, instantiated three times. Interface: request in, `hi`/`lo` gates out, parameter `DEAD_CYCLES`.

## Test plan
1. **Reset and first valid code:** assert `reset_n`=0 with halls 100, `enable`=1, `duty`=128, `dir`=0, then release.
   - All gates stay 0 until clock 6 after release.
   - `sector`=0.
   - `inha` then toggles 128 on / 128 off, and `inlb` is steady 1.
2. **Hall glitch:** hold 100, then pulse 110 for 3 clocks.
   - Sector never changes.
   - A 110 held for ≥6 clocks gives `sector`=1: `inha` continues PWM, `inlb`→0, `inlc`→1 one clock later.
3. **Dead time, reverse:** switch `dir` 0→1 in sector 0.
   - A: `inha`→0, then `inla`=1 exactly 12 clocks later.
   - B: `inlb`→0, then `inhb` PWM starts after 12 clocks.
   - Both gates of a phase are never 1 together.
4. **Invalid codes:** drive halls 000 and then 111.
   - `fault`=1, `sector`=7, all gates 0.
   - Restoring 010 clears `fault` and gives `sector`=2.
5. **Duty boundaries:**
   - `duty`=0: the high side is never on.
   - `duty`=255: the high side is off exactly 1 clock per 256.
   - A duty change mid-period takes effect only after the wrap.
6. **Period measurement:**
   - Step sectors 0→1→2 with 1000 clocks between the accepted changes: `period`=1000 with one-cycle `period_valid`.
   - Hold one sector for more than 2^24 clocks: the counter saturates, and the next change reports 0xFFFFFF.
